// File: rtl/num_stream_tokenizer.sv
// Streaming ASCII-to-integer tokenizer: splits a valid/ready byte stream into
// signed decimal tokens and emits saturated two's-complement values.
module num_stream_tokenizer #(
    parameter int OUT_W       = 32,
    parameter int CNT_W       = 11,
    parameter int MULTI_DELIM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [OUT_W-1:0] out_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] num_count,
    output logic             parse_done,
    output logic             err_invalid_char,
    output logic             err_overflow
);

    localparam int ACC_W = OUT_W + 4;
    localparam logic [OUT_W-1:0] POS_LIMIT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_LIMIT = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_SKIP, S_NUM, S_EMIT, S_DONE, S_ERROR
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] mag;
    logic             neg;
    logic             have_digit;

    logic             is_digit;
    logic             is_minus;
    logic             is_delim;
    logic             accept;
    logic             base_neg;
    logic             sat;
    logic [OUT_W-1:0] base_mag;
    logic [OUT_W-1:0] limit;
    logic [OUT_W-1:0] acc_mag;
    logic [OUT_W-1:0] acc_value;
    logic [OUT_W-1:0] mag_value;
    logic [ACC_W-1:0] product;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_minus = (in_data == 8'h2D);
        is_delim = (in_data == 8'h20);
        if (MULTI_DELIM != 0) begin
            is_delim = is_delim || (in_data == 8'h2C) || (in_data == 8'h09) ||
                       (in_data == 8'h0D) || (in_data == 8'h0A);
        end
        accept    = in_valid && in_ready;
        // A digit seen in SKIP starts a fresh positive token from zero.
        base_neg  = (state == S_NUM) && neg;
        base_mag  = (state == S_NUM) ? mag : '0;
        limit     = base_neg ? NEG_LIMIT : POS_LIMIT;
        product   = ACC_W'(base_mag) * ACC_W'(10) + ACC_W'(in_data[3:0]);
        sat       = product > ACC_W'(limit);
        acc_mag   = sat ? limit : product[OUT_W-1:0];
        acc_value = base_neg ? -acc_mag : acc_mag;
        mag_value = neg ? -mag : mag;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only plain registers here; there is no storage array needing a reset policy.
            state            <= S_IDLE;
            mag              <= '0;
            neg              <= 1'b0;
            have_digit       <= 1'b0;
            in_ready         <= 1'b0;
            out_value        <= '0;
            out_valid        <= 1'b0;
            out_last         <= 1'b0;
            num_count        <= '0;
            parse_done       <= 1'b0;
            err_invalid_char <= 1'b0;
            err_overflow     <= 1'b0;
        end else if (clear) begin
            state            <= S_IDLE;
            mag              <= '0;
            neg              <= 1'b0;
            have_digit       <= 1'b0;
            in_ready         <= 1'b0;
            out_value        <= '0;
            out_valid        <= 1'b0;
            out_last         <= 1'b0;
            num_count        <= '0;
            parse_done       <= 1'b0;
            err_invalid_char <= 1'b0;
            err_overflow     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state            <= S_SKIP;
                        in_ready         <= 1'b1;
                        num_count        <= '0;
                        err_invalid_char <= 1'b0;
                        err_overflow     <= 1'b0;
                    end
                end
                S_SKIP, S_NUM: begin
                    if (accept) begin
                        if (is_digit) begin
                            mag        <= acc_mag;
                            neg        <= base_neg;
                            have_digit <= 1'b1;
                            if (sat) err_overflow <= 1'b1;
                            if (in_last) begin
                                state     <= S_EMIT;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                out_value <= acc_value;
                                out_last  <= 1'b1;
                            end else begin
                                state <= S_NUM;
                            end
                        end else if (is_delim && state == S_SKIP) begin
                            if (in_last) begin
                                state      <= S_DONE;
                                in_ready   <= 1'b0;
                                parse_done <= 1'b1;
                            end
                        end else if (is_delim && have_digit) begin
                            state     <= S_EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_value <= mag_value;
                            out_last  <= in_last;
                        end else if (is_minus && state == S_SKIP && !in_last) begin
                            state      <= S_NUM;
                            mag        <= '0;
                            neg        <= 1'b1;
                            have_digit <= 1'b0;
                        end else begin
                            state            <= S_ERROR;
                            in_ready         <= 1'b0;
                            parse_done       <= 1'b1;
                            err_invalid_char <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (num_count != '1) num_count <= num_count + CNT_W'(1);
                        if (out_last) begin
                            state      <= S_DONE;
                            parse_done <= 1'b1;
                        end else begin
                            state    <= S_SKIP;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state        <= S_SKIP;
                        in_ready     <= 1'b1;
                        parse_done   <= 1'b0;
                        num_count    <= '0;
                        err_overflow <= 1'b0;
                    end
                end
                S_ERROR: begin
                    // Held until clear or reset; start is deliberately ignored.
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/num_stream_tokenizer.md
Name: num_stream_tokenizer

Overview:
- Streaming successor to the buffer-based character parser.
- Consumes an ASCII byte stream over a valid/ready handshake, splits it into signed decimal tokens and converts each token internally.
- Emits two's-complement integers of parameterised width over a valid/ready handshake, with an optional multi-delimiter mode.
- Sits between the UART payload path and the matrix element loader; no payload buffer array is needed.

Parameters:
- OUT_W, 32, output integer width in bits (2..64).
- CNT_W, 11, token counter width.
- MULTI_DELIM, 1. 0 = space (0x20) is the only delimiter. 1 = space, comma (0x2C), tab (0x09), CR (0x0D) and LF (0x0A) are delimiters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear to IDLE; wins over every other input.
- start  in  1  begin a new stream; sampled in IDLE and DONE.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_last  in  1  qualifies the final byte of the stream.
- out_value  out  OUT_W  signed converted token.
- out_valid  out  1  token available.
- out_ready  in  1  downstream accepts the token.
- out_last  out  1  token is the last of the stream.
- num_count  out  CNT_W  tokens emitted since start; saturates at all-ones.
- parse_done  out  1  high in DONE or ERROR.
- err_invalid_char  out  1  sticky; set on entering ERROR.
- err_overflow  out  1  sticky; a token saturated.

Behaviour:
- Reset (rst_n low) and clear both give: state IDLE, all outputs 0, accumulator 0, sign 0, sticky flags 0.
- Clear does this synchronously. rst_n does it asynchronously.
- States: IDLE, SKIP, NUM, EMIT, DONE, ERROR.
- IDLE:
  - in_ready=0.
  - start -> SKIP; num_count and both sticky flags cleared.
- SKIP: in_ready=1. On an accepted byte:
  - Delimiter: stay in SKIP. If in_last -> DONE; no token is emitted.
  - '-': mag=0, neg=1, have_digit=0 -> NUM. If in_last -> ERROR (lone minus).
  - Digit: mag=d, neg=0, have_digit=1 -> NUM. If in_last -> EMIT with last flag set.
  - Any other byte -> ERROR.
- NUM: in_ready=1. On an accepted byte:
  - Digit: mag=mag*10+d, have_digit=1. If in_last -> EMIT with last=1.
  - Delimiter: if have_digit -> EMIT with last=in_last; otherwise -> ERROR.
  - '-' or any other byte -> ERROR.
- Arithmetic and saturation:
  - mag is an unsigned OUT_W-bit register; *10 is computed in OUT_W+4 bits.
  - Limit is 2^(OUT_W-1)-1 when neg=0 and 2^(OUT_W-1) when neg=1.
  - If the product plus the digit exceeds the limit, mag holds the limit and err_overflow is set.
  - Remaining digits of the token are still consumed; mag stays at the limit.
- EMIT:
  - in_ready=0; out_valid=1.
  - out_value = neg ? -mag : mag. Example: "-2147483648" gives 0x80000000 for OUT_W=32.
  - out_value and out_last are held stable until out_ready.
  - On handshake: num_count increments (saturating), then -> DONE if last, else -> SKIP.
  - Latency: out_valid rises the cycle after the terminating byte is accepted.
- DONE:
  - parse_done=1, in_ready=0.
  - start -> SKIP with counters cleared (back-to-back streams).
- ERROR:
  - parse_done=1, err_invalid_char=1, in_ready=0.
  - Exits only on clear or reset; start is ignored.
- in_last arriving on the delimiter byte that closes a token: the token is emitted with out_last=1, then -> DONE.
- Consecutive delimiters of any mix are skipped; they never produce empty tokens.
- in_valid low: no state change. The accumulator holds across any number of stall cycles.
- Reset or clear during EMIT: the pending token is dropped and out_valid falls immediately (asynchronously for rst_n).
- With MULTI_DELIM=0, comma, tab, CR and LF go to ERROR.

Test Plan:
- MULTI_DELIM=1, stream "  12,-7\n0" with in_last on '0', out_ready=1 -> tokens 12, -7, 0; out_last only on 0; num_count=3; parse_done=1; no error flags.
- OUT_W=32, tokens "2147483648" and "-2147483649" -> outputs 0x7FFFFFFF and 0x80000000; err_overflow=1; parse_done=1 after the last token.
- Stream "5 - 3" with in_last on '3' -> token 5 emitted; the lone '-' then a space goes to ERROR; err_invalid_char=1; in_ready=0; num_count=1.
- out_ready held low for 10 cycles during "99 1" -> out_value=99 stable with out_valid=1 throughout; in_ready=0; then token 1 follows; num_count=2.
- Random in_valid gaps (50%) on "100 200" -> same tokens as the gap-free run; clear mid-token -> IDLE with all outputs 0; a new start then parses "8" correctly.
- MULTI_DELIM=0, stream "1,2" -> ERROR on the comma; no token emitted; err_invalid_char=1.
